// File: rtl/instr_encoder.sv
// Streaming field-to-word instruction encoder that loads consecutive instruction-memory words.
module instr_encoder #(
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [1:0]        in_op,
    input  logic [3:0]        in_cond,
    input  logic [5:0]        in_funct,
    input  logic [3:0]        in_rn,
    input  logic [3:0]        in_rd,
    input  logic [23:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam int unsigned       CNT_W     = ADDR_W + 1;
    localparam int unsigned       DEPTH     = 1 << ADDR_W;
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_in_ready;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic               r_busy;
    logic               r_done;
    logic               r_full;
    logic               r_err;
    logic [CNT_W-1:0]   r_count;

    logic               w_accept;
    logic               w_illegal;
    logic               w_write;
    logic               w_full_hit;
    logic               w_session_start;
    logic [CNT_W-1:0]   w_count_inc;
    logic [31:0]        w_word;

    // Handshake, legality, field packing and next-state selection.
    always_comb begin
        w_state_nxt     = r_state;
        w_full_hit      = 1'b0;
        w_session_start = (r_state == S_IDLE) && start;
        w_accept        = (r_state == S_LOAD) && r_in_ready && in_valid;
        w_illegal       = (in_op == 2'b11) || ((in_op == 2'b10) && !in_funct[5]);
        w_write         = w_accept && !w_illegal;
        w_count_inc     = r_count + CNT_W'(1);
        if (in_op == 2'b10) begin
            w_word = {in_cond, 2'b10, in_funct[5:4], in_imm};
        end else begin
            w_word = {in_cond, in_op, in_funct, in_rn, in_rd, in_imm[11:0]};
        end

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_accept) begin
                    if (in_last) begin
                        w_state_nxt = S_DRAIN;
                    end else if (w_write && (w_count_inc == DEPTH_CNT)) begin
                        w_state_nxt = S_DRAIN;
                        w_full_hit  = 1'b1;
                    end
                end
            end
            S_DRAIN: w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered handshake/status outputs, write port and session counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_in_ready <= (w_state_nxt == S_LOAD);
            r_busy     <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_DRAIN);
            r_done     <= (w_state_nxt == S_DONE);
            r_we       <= w_write;
            if (w_write) begin
                r_addr  <= BASE + r_count[ADDR_W-1:0];
                r_wdata <= w_word;
            end
            if (w_session_start) begin
                r_count <= '0;
                r_full  <= 1'b0;
                r_err   <= 1'b0;
            end else begin
                if (w_write) begin
                    r_count <= w_count_inc;
                end
                if (w_full_hit) begin
                    r_full <= 1'b1;
                end
                if (w_accept && w_illegal) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign busy      = r_busy;
    assign done      = r_done;
    assign full      = r_full;
    assign err       = r_err;
    assign count     = r_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: encoding table, hand-built corner sessions and random sessions vs a model.
module tb_instr_encoder;

    localparam int unsigned ADDR_W    = 2;
    localparam int unsigned BASE_ADDR = 0;
    localparam int unsigned DEPTH     = 1 << ADDR_W;

    typedef struct {
        logic [3:0]  cond;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [23:0] imm;
        logic        last;
    } beat_t;

    typedef struct {
        beat_t       b;
        logic        legal;
        logic [31:0] word;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [1:0]        in_op;
    logic [3:0]        in_cond;
    logic [5:0]        in_funct;
    logic [3:0]        in_rn;
    logic [3:0]        in_rd;
    logic [23:0]       in_imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              full;
    logic              err;
    logic [ADDR_W:0]   count;

    int          n_vec = 0;
    int          n_err = 0;
    beat_t       q_beats[$];
    logic [31:0] last_wdata;

    instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) u_dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .in_op(in_op), .in_cond(in_cond), .in_funct(in_funct),
        .in_rn(in_rn), .in_rd(in_rd), .in_imm(in_imm), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .full(full), .err(err), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic beat_t mk(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                                 input logic [3:0] n, input logic [3:0] d, input logic [23:0] i,
                                 input logic l);
        beat_t b;
        b.cond = c; b.op = o; b.funct = f; b.rn = n; b.rd = d; b.imm = i; b.last = l;
        return b;
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        b.cond  = 4'($urandom_range(15));
        b.op    = 2'($urandom_range(3));
        b.funct = 6'($urandom_range(63));
        b.rn    = 4'($urandom_range(15));
        b.rd    = 4'($urandom_range(15));
        b.imm   = 24'($urandom);
        b.last  = 1'b0;
        return b;
    endfunction

    function automatic bit is_legal(input beat_t b);
        if (b.op == 2'd3) return 1'b0;
        if (b.op == 2'd2 && b.funct < 6'd32) return 1'b0;
        return 1'b1;
    endfunction

    // Reference encoding from field positions with plain arithmetic.
    function automatic logic [31:0] model_word(input beat_t b);
        int unsigned w;
        if (b.op == 2'd2) begin
            w = (32'(b.cond) << 28) + (32'd2 << 26) + ((32'(b.funct) / 16) << 24) + 32'(b.imm);
        end else begin
            w = (32'(b.cond) << 28) + (32'(b.op) << 26) + (32'(b.funct) << 20)
              + (32'(b.rn) << 16) + (32'(b.rd) << 12) + (32'(b.imm) % 4096);
        end
        return w;
    endfunction

    task automatic put_beat(input beat_t b);
        in_valid = 1'b1;
        in_cond  = b.cond;
        in_op    = b.op;
        in_funct = b.funct;
        in_rn    = b.rn;
        in_rd    = b.rd;
        in_imm   = b.imm;
        in_last  = b.last;
    endtask

    // One load session from q_beats: model predicts writes and final status; bench checks cycle by cycle.
    task automatic run_session(input int bubble_pct, input bit valid_at_start);
        logic [31:0] exp_w[$];
        logic [31:0] exp_a[$];
        int m_cnt  = 0;
        bit m_full = 1'b0;
        bit m_err  = 1'b0;
        int m_acc  = 0;
        int bi     = 0;
        int nwr    = 0;
        bit fin    = 1'b0;
        bit acc;
        bit exp_we;
        foreach (q_beats[i]) begin
            m_acc++;
            if (is_legal(q_beats[i])) begin
                exp_w.push_back(model_word(q_beats[i]));
                exp_a.push_back((BASE_ADDR + m_cnt) % DEPTH);
                m_cnt++;
            end else begin
                m_err = 1'b1;
            end
            if (q_beats[i].last) break;
            if (m_cnt == DEPTH) begin
                m_full = 1'b1;
                break;
            end
        end

        chk("idle_in_ready", 32'(in_ready), 32'd0);
        start = 1'b1;
        if (valid_at_start) put_beat(q_beats[0]);
        else in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);

        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            if (bi < m_acc) chk("in_ready_stream", 32'(in_ready), 32'd1);
            if (bi < q_beats.size() && $urandom_range(99) >= bubble_pct) put_beat(q_beats[bi]);
            else in_valid = 1'b0;
            acc    = in_valid && in_ready;
            exp_we = 1'b0;
            if (acc && bi < q_beats.size()) exp_we = is_legal(q_beats[bi]);
            @(posedge clk); #1;
            if (acc) bi++;
            chk("mem_we", 32'(mem_we), 32'(exp_we));
            if (mem_we) begin
                if (nwr < exp_w.size()) begin
                    chk("mem_addr", 32'(mem_addr), exp_a[nwr]);
                    chk("mem_wdata", mem_wdata, exp_w[nwr]);
                end
                last_wdata = mem_wdata;
                nwr++;
            end
            if (done) begin
                fin = 1'b1;
                chk("count", 32'(count), 32'(m_cnt));
                chk("full", 32'(full), 32'(m_full));
                chk("err", 32'(err), 32'(m_err));
                chk("busy_at_done", 32'(busy), 32'd0);
                chk("in_ready_at_done", 32'(in_ready), 32'd0);
            end
        end
        in_valid = 1'b0;
        if (!fin) begin
            n_vec++;
            n_err++;
            $display("FAIL session_timeout: no done pulse within 200 cycles");
        end
        chk("write_total", 32'(nwr), 32'(exp_w.size()));
        chk("accepted_total", 32'(bi), 32'(m_acc));
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("count_hold", 32'(count), 32'(m_cnt));
        chk("err_hold", 32'(err), 32'(m_err));
    endtask

    initial begin
        vec_t  tbl[8];
        beat_t b;
        int    nleg;

        tbl[0] = '{mk(4'hE, 2'b00, 6'b101000, 4'h3, 4'h2, 24'h000005, 1'b1), 1'b1, 32'hE2832005};
        tbl[1] = '{mk(4'hE, 2'b01, 6'b011001, 4'h0, 4'h1, 24'h000004, 1'b1), 1'b1, 32'hE5901004};
        tbl[2] = '{mk(4'hE, 2'b10, 6'b100000, 4'h0, 4'h0, 24'hFFFFFE, 1'b1), 1'b1, 32'hEAFFFFFE};
        tbl[3] = '{mk(4'h0, 2'b10, 6'b110000, 4'h0, 4'h0, 24'h000010, 1'b1), 1'b1, 32'h0B000010};
        tbl[4] = '{mk(4'h1, 2'b01, 6'b011000, 4'hD, 4'h0, 24'h000ABC, 1'b1), 1'b1, 32'h158D0ABC};
        tbl[5] = '{mk(4'hE, 2'b00, 6'b000100, 4'h1, 4'h2, 24'hFFF003, 1'b1), 1'b1, 32'hE0412003};
        tbl[6] = '{mk(4'hA, 2'b10, 6'b101111, 4'hF, 4'hF, 24'h123456, 1'b1), 1'b1, 32'hAA123456};
        tbl[7] = '{mk(4'hE, 2'b11, 6'b000000, 4'h1, 4'h1, 24'h000001, 1'b1), 1'b0, 32'h0};

        reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_op = '0; in_cond = '0;
        in_funct = '0; in_rn = '0; in_rd = '0; in_imm = '0; last_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_status", {28'd0, busy, done, full, err}, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Encoding table, one single-beat session each.
        for (int i = 0; i < 8; i++) begin
            q_beats.delete();
            q_beats.push_back(tbl[i].b);
            last_wdata = 32'hDEAD_BEEF;
            run_session(0, 1'b0);
            if (tbl[i].legal) chk($sformatf("tbl%0d_word", i), last_wdata, tbl[i].word);
            chk($sformatf("tbl%0d_err", i), 32'(err), 32'(!tbl[i].legal));
        end

        // Mixed back-to-back LDR then B.
        q_beats.delete();
        q_beats.push_back(mk(4'hE, 2'b01, 6'b011001, 4'h0, 4'h1, 24'h000004, 1'b0));
        q_beats.push_back(mk(4'hE, 2'b10, 6'b100000, 4'h0, 4'h0, 24'hFFFFFE, 1'b1));
        run_session(0, 1'b0);
        chk("t2_count", 32'(count), 32'd2);

        // Illegal beat between two legal beats.
        q_beats.delete();
        q_beats.push_back(mk(4'hE, 2'b00, 6'b101000, 4'h3, 4'h2, 24'h000005, 1'b0));
        q_beats.push_back(mk(4'hE, 2'b11, 6'b101000, 4'h3, 4'h2, 24'h000005, 1'b0));
        q_beats.push_back(mk(4'hE, 2'b01, 6'b011001, 4'h0, 4'h1, 24'h000004, 1'b1));
        run_session(0, 1'b0);
        chk("t3_err", 32'(err), 32'd1);
        chk("t3_count", 32'(count), 32'd2);

        // Overflow: five legal beats without last.
        q_beats.delete();
        for (int i = 0; i < 5; i++) q_beats.push_back(mk(4'hE, 2'b00, 6'(i), 4'(i), 4'h1, 24'(i), 1'b0));
        run_session(0, 1'b0);
        chk("t4_full", 32'(full), 32'd1);
        chk("t4_count", 32'(count), 32'd4);

        // Reset right after a beat is accepted discards the pending write.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        put_beat(mk(4'hE, 2'b00, 6'b101000, 4'h3, 4'h2, 24'h000005, 1'b0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("t5_mem_we", 32'(mem_we), 32'd0);
        chk("t5_mem_wdata", mem_wdata, 32'd0);
        chk("t5_mem_addr", 32'(mem_addr), 32'd0);
        chk("t5_status", {28'd0, busy, done, full, err}, 32'd0);
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        q_beats.delete();
        q_beats.push_back(mk(4'h5, 2'b00, 6'b010010, 4'h7, 4'h8, 24'h000ABC, 1'b0));
        q_beats.push_back(mk(4'h6, 2'b01, 6'b011000, 4'h9, 4'hA, 24'h000123, 1'b1));
        run_session(0, 1'b0);

        // Beat presented together with start is taken only once LOAD is reached.
        q_beats.delete();
        q_beats.push_back(mk(4'hE, 2'b00, 6'b101000, 4'h3, 4'h2, 24'h000005, 1'b1));
        run_session(0, 1'b1);
        chk("t6_count", 32'(count), 32'd1);

        // Random sessions with bubbles, illegal beats, early last and overflow.
        for (int s = 0; s < 30; s++) begin
            q_beats.delete();
            nleg = 0;
            do begin
                b = rand_beat();
                b.last = ($urandom_range(99) < 20);
                q_beats.push_back(b);
                if (is_legal(b)) nleg++;
            end while (!b.last && nleg < DEPTH);
            if ($urandom_range(1) == 1) q_beats.push_back(rand_beat());
            run_session(30, ($urandom_range(3) == 0));
            repeat ($urandom_range(2)) @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
